// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl - hardware interrupt controller feeding the cu's hwint input.
//
// Each peripheral line is synchronised through two flops, rising edges are
// latched into pending bits, pending is masked by a software-writable enable
// register, and the lowest-numbered active source is presented as a vector.
// Configuration and acknowledgement are done through a small memory-mapped
// slave on the cpu data bus.
//
// Register map (addr):
//   0 PENDING  read; write-1-to-clear
//   1 ENABLE   read/write, bits [NUM_IRQ-1:0]
//   2 VECTOR   read only: bit 31 = any source active, bits [4:0] = vector
//   3 SET      write-1-to-set pending (software interrupt); reads 0
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       asynchronous reset, active-low
//   irq       peripheral interrupt lines, asynchronous, level-high
//   sel       bus chip select; rd / wr are qualified by it
//   rd, wr    bus read / write strobes
//   addr      register index
//   data_in   bus write data
//   data_out  bus read data, registered (valid the cycle after the strobe)
//   hwint     registered interrupt request to the cu
//   int_ack   one-cycle pulse from the cu entering the interrupt sequence
//   vector    index of the currently selected source (0 when none active)
//
// WIDTH must be at least 32 (VECTOR uses bit 31) and NUM_IRQ in 1..32.
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               sel,
    input  logic               rd,
    input  logic               wr,
    input  logic [1:0]         addr,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               hwint,
    input  logic               int_ack,
    output logic [4:0]         vector
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_VECTOR  = 2'd2;
    localparam logic [1:0] ADDR_SET     = 2'd3;

    // State
    logic [NUM_IRQ-1:0] sync1_q,   sync1_d;
    logic [NUM_IRQ-1:0] sync2_q,   sync2_d;
    logic [NUM_IRQ-1:0] prev_q,    prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q,  enable_d;
    logic               hwint_q,   hwint_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;

    // Combinational helpers
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] set_sw;
    logic [NUM_IRQ-1:0] w1c;
    logic [4:0]         sel_idx;
    logic               wr_en;
    logic               rd_en;
    logic [WIDTH-1:0]   rd_data;

    assign wr_en  = sel & wr;
    assign rd_en  = sel & rd;
    assign rise   = sync2_q & ~prev_q;
    assign active = pending_q & enable_q;

    // Priority encoder: scanning from the top down leaves the lowest active
    // index in sel_idx, so bit 0 has the highest priority.
    // NOTE: every variable assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel_idx = 5'(i);
            end
        end
    end

    // int_ack clears exactly the selected source: x & -x isolates the lowest
    // set bit, which is the same bit sel_idx points at (and nothing if idle).
    assign ack_clr = int_ack ? (active & (~active + NUM_IRQ'(1))) : '0;

    assign set_sw = (wr_en && addr == ADDR_SET)     ? data_in[NUM_IRQ-1:0] : '0;
    assign w1c    = (wr_en && addr == ADDR_PENDING) ? data_in[NUM_IRQ-1:0] : '0;

    // Read mux; unimplemented bits stay zero.
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_PENDING: rd_data[NUM_IRQ-1:0] = pending_q;
            ADDR_ENABLE:  rd_data[NUM_IRQ-1:0] = enable_q;
            ADDR_VECTOR: begin
                rd_data[31]  = |active;
                rd_data[4:0] = sel_idx;
            end
            default:      rd_data = '0;
        endcase
    end

    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        // Clears are applied first and sets last, so a fresh hardware edge
        // beats both int_ack and W1C, and a software SET beats int_ack.
        pending_d = (pending_q & ~ack_clr & ~w1c) | set_sw | rise;

        enable_d = enable_q;
        if (wr_en && addr == ADDR_ENABLE) begin
            enable_d = data_in[NUM_IRQ-1:0];
        end

        hwint_d = |active;

        // rd_data is built from the current (pre-write) registers, so a
        // simultaneous read and write returns the old value.
        data_out_d = data_out_q;
        if (rd_en) begin
            data_out_d = rd_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            hwint_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            hwint_q    <= hwint_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign hwint    = hwint_q;
    assign vector   = sel_idx;

    // Upper write-data bits have no register behind them.
    if (WIDTH > NUM_IRQ) begin : g_unused_data
        logic unused_data_in_hi;
        assign unused_data_in_hi = ^data_in[WIDTH-1:NUM_IRQ];
    end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl - directed self-checking bench for int_ctrl (NUM_IRQ=8,
// WIDTH=32). Inputs change and outputs are sampled 1 time unit after each
// rising edge; every expected value below is worked out by hand from the
// controller's described timing.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  irq;
    logic        sel;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        hwint;
    logic        int_ack;
    logic [4:0]  vector;

    int n_vec;
    int n_miss;

    int_ctrl #(.NUM_IRQ(8), .WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .sel      (sel),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .hwint    (hwint),
        .int_ack  (int_ack),
        .vector   (vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; data_in = d;
        tick();
        sel = 1'b0; wr = 1'b0; data_in = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; rd = 1'b1; addr = a;
        tick();
        d = data_out;
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    logic [31:0] rv;

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        rst     = 1'b0;
        irq     = 8'hFF;
        sel     = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        int_ack = 1'b0;

        // ---- Reset and idle -------------------------------------------------
        tick(2);
        check("rst_hwint",    {31'd0, hwint}, 32'd0);
        check("rst_data_out", data_out,       32'd0);
        check("rst_vector",   {27'd0, vector}, 32'd0);

        rst = 1'b1;
        tick(3);                        // edges 1..3: pending sets at edge 3
        bus_read(2'd0, rv);             // strobe sampled at edge 4
        check("rst_release_pending", rv, 32'h0000_00FF);
        check("rst_release_hwint", {31'd0, hwint}, 32'd0);

        // A held-high line is not re-latched after being cleared.
        bus_write(2'd0, 32'h0000_00FF);
        tick(2);
        bus_read(2'd0, rv);
        check("held_no_retrigger", rv, 32'd0);

        irq = 8'h00;
        tick(3);

        // ---- Basic latency --------------------------------------------------
        bus_write(2'd1, 32'h0000_0004);
        irq[2] = 1'b1;
        tick();                          // edge k: first sample
        check("lat_k_vector",  {27'd0, vector}, 32'd0);
        tick();                          // k+1: rise high
        check("lat_k1_vector", {27'd0, vector}, 32'd0);
        tick();                          // k+2: pending[2] set
        check("lat_k2_vector", {27'd0, vector}, 32'd2);
        check("lat_k2_hwint",  {31'd0, hwint},  32'd0);
        tick();                          // k+3: hwint rises
        check("lat_k3_hwint",  {31'd0, hwint},  32'd1);
        bus_read(2'd2, rv);
        check("lat_vector_reg", rv, 32'h8000_0002);
        ack_pulse();
        check("lat_ack_vector", {27'd0, vector}, 32'd0);
        check("lat_ack_hwint_lag", {31'd0, hwint}, 32'd1);
        tick();
        check("lat_ack_hwint_low", {31'd0, hwint}, 32'd0);
        irq = 8'h00;
        tick(3);

        // ---- Priority and ack -----------------------------------------------
        bus_write(2'd1, 32'h0000_00FF);
        bus_write(2'd3, 32'h0000_0028);
        check("prio_vector3", {27'd0, vector}, 32'd3);
        tick();
        check("prio_hwint", {31'd0, hwint}, 32'd1);
        ack_pulse();
        check("prio_vector5", {27'd0, vector}, 32'd5);
        check("prio_hwint_after_ack1", {31'd0, hwint}, 32'd1);
        bus_read(2'd0, rv);
        check("prio_pending_20", rv, 32'h0000_0020);
        ack_pulse();
        check("prio_vector0", {27'd0, vector}, 32'd0);
        check("prio_hwint_lag", {31'd0, hwint}, 32'd1);
        tick();
        check("prio_hwint_low", {31'd0, hwint}, 32'd0);

        // ---- Collision: rise[3] and int_ack on bit 3 at the same edge -------
        bus_write(2'd3, 32'h0000_0008);
        irq[3] = 1'b1;
        tick(2);                         // edges k, k+1: rise[3] now high
        int_ack = 1'b1;
        tick();                          // k+2: ack and rise collide
        int_ack = 1'b0;
        bus_read(2'd0, rv);
        check("collide_pending", rv, 32'h0000_0008);
        ack_pulse();                     // no rise now: ack clears it
        check("collide_cleared_vector", {27'd0, vector}, 32'd0);
        irq = 8'h00;
        tick(3);

        // ---- Software SET / W1C / ignored VECTOR write ----------------------
        bus_write(2'd3, 32'h0000_0080);
        bus_read(2'd0, rv);
        check("set_pending7", rv, 32'h0000_0080);
        check("set_vector7", {27'd0, vector}, 32'd7);
        bus_write(2'd0, 32'h0000_0080);
        bus_read(2'd0, rv);
        check("w1c_pending", rv, 32'd0);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd0, rv);
        check("vecwr_pending", rv, 32'd0);
        bus_read(2'd1, rv);
        check("vecwr_enable", rv, 32'h0000_00FF);
        bus_read(2'd3, rv);
        check("set_reads_zero", rv, 32'd0);

        // ---- Read timing and read/write collision ---------------------------
        bus_read(2'd1, rv);
        check("rd_enable", data_out, 32'h0000_00FF);
        tick(2);
        check("rd_hold", data_out, 32'h0000_00FF);
        sel = 1'b1; rd = 1'b1; wr = 1'b1; addr = 2'd1; data_in = 32'hFFFF_FF0F;
        tick();
        sel = 1'b0; rd = 1'b0; wr = 1'b0; data_in = '0;
        check("rdwr_old_value", data_out, 32'h0000_00FF);
        bus_read(2'd1, rv);
        check("rdwr_new_value", rv, 32'h0000_000F);

        // ---- Masking keeps pending; re-enable re-raises hwint ---------------
        bus_write(2'd3, 32'h0000_0080);
        tick(2);
        check("mask_hwint_off", {31'd0, hwint}, 32'd0);
        check("mask_vector", {27'd0, vector}, 32'd0);
        bus_write(2'd1, 32'h0000_00FF);
        check("reen_vector", {27'd0, vector}, 32'd7);
        tick();
        check("reen_hwint", {31'd0, hwint}, 32'd1);

        // ---- Mid-operation reset --------------------------------------------
        bus_read(2'd0, rv);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_data_out", data_out, 32'd0);
        check("midrst_hwint", {31'd0, hwint}, 32'd0);
        check("midrst_vector", {27'd0, vector}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        bus_read(2'd0, rv);
        check("midrst_pending", rv, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
